// File: rtl/cntr_pkg.sv
// Shared state codes for the parametrised counter.
// States are plain 3-bit codes rather than an enum so that illegal codes remain representable.
package cntr_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE = 3'b000;
  localparam state_t LOAD = 3'b001;
  localparam state_t INC  = 3'b010;
  localparam state_t DEC  = 3'b011;
  localparam state_t HOLD = 3'b100;

endpackage

// File: rtl/cntr_param_if.sv
// Control/data bundle for cntr_param.
// The master drives the load/enable/direction inputs; the slave returns count, state and terminal count.
interface cntr_param_if #(parameter int WIDTH = 8);
  import cntr_pkg::*;

  logic               load;
  logic               en;
  logic               inc;
  logic [WIDTH-1:0]   d_in;
  logic [WIDTH-1:0]   d_out;
  logic [STATE_W-1:0] o_state;
  logic               tc;

  modport master (output load, en, inc, d_in, input  d_out, o_state, tc);
  modport slave  (input  load, en, inc, d_in, output d_out, o_state, tc);

endinterface

// File: rtl/cntr_ns_logic.sv
// Combinational next-state logic for cntr_param.
// Every legal state uses the same priority; any illegal code falls back to IDLE.
module cntr_ns_logic
  import cntr_pkg::*;
(
  input  logic   load,
  input  logic   en,
  input  logic   inc,
  input  state_t state,
  output state_t next_state
);

  always_comb begin
    next_state = IDLE;
    if (state <= HOLD) begin
      if (load)     next_state = LOAD;
      else if (!en) next_state = HOLD;
      else if (inc) next_state = INC;
      else          next_state = DEC;
    end
  end

endmodule

// File: rtl/cntr_param.sv
// Parametrised loadable up/down counter: registered FSM plus a registered count and tc.
// Define CNTR_SAT_EN to clamp at 0 / 2^WIDTH-1 instead of wrapping.
module cntr_param
  import cntr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic         clk,
  input  logic         reset,
  cntr_param_if.slave  bus
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX    = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   sum, diff;

  cntr_ns_logic u_ns (
    .load       (bus.load),
    .en         (bus.en),
    .inc        (bus.inc),
    .state      (state_q),
    .next_state (state_d)
  );

  // Carry out of the extra top bit flags overflow on add and borrow on subtract.
  assign sum  = {1'b0, cnt_q} + STEP_X;
  assign diff = {1'b0, cnt_q} - STEP_X;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    case (state_q)
      IDLE: cnt_d = '0;
      LOAD: cnt_d = bus.d_in;
      INC: begin
`ifdef CNTR_SAT_EN
        if (sum[WIDTH]) begin
          cnt_d = MAX;
          tc_d  = 1'b1;
        end else begin
          cnt_d = sum[WIDTH-1:0];
          tc_d  = (sum[WIDTH-1:0] == MAX);
        end
`else
        cnt_d = sum[WIDTH-1:0];
        tc_d  = sum[WIDTH] | (sum[WIDTH-1:0] == MAX);
`endif
      end
      DEC: begin
`ifdef CNTR_SAT_EN
        if (diff[WIDTH]) begin
          cnt_d = '0;
          tc_d  = 1'b1;
        end else begin
          cnt_d = diff[WIDTH-1:0];
          tc_d  = (diff[WIDTH-1:0] == '0);
        end
`else
        cnt_d = diff[WIDTH-1:0];
        tc_d  = diff[WIDTH] | (diff[WIDTH-1:0] == '0);
`endif
      end
      HOLD: cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.d_out   = cnt_q;
  assign bus.o_state = state_q;
  assign bus.tc      = tc_q;

endmodule

// File: tb/tb_cntr_param.sv
// Scoreboard bench for cntr_param: an 8-bit/STEP=1 instance and a 4-bit/STEP=3 instance.
// The driver queues hand-computed results; a monitor pops one per clock and compares.
module tb_cntr_param;

  localparam bit SAT =
`ifdef CNTR_SAT_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    bit         sel;
    logic [7:0] cnt;
    bit         tc;
    logic [2:0] st;
    string      nm;
  } exp_t;

  logic clk, reset;
  exp_t q[$];
  int   n_chk, n_pass;

  cntr_param_if #(.WIDTH(8)) if8 ();
  cntr_param_if #(.WIDTH(4)) if4 ();

  cntr_param #(.WIDTH(8), .STEP(1)) u8 (.clk(clk), .reset(reset), .bus(if8));
  cntr_param #(.WIDTH(4), .STEP(3)) u4 (.clk(clk), .reset(reset), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input bit sel, input logic [7:0] ec, input bit et,
                      input logic [2:0] es, input string nm);
    exp_t e;
    e.sel = sel; e.cnt = ec; e.tc = et; e.st = es; e.nm = nm;
    q.push_back(e);
  endtask

  // Inputs change on the falling edge; the result is expected after the next rising edge.
  task automatic row(input bit sel, input bit l, input bit e, input bit i, input logic [7:0] d,
                     input logic [7:0] ec, input bit et, input logic [2:0] es, input string nm);
    @(negedge clk);
    if (!sel) begin
      if8.load = l; if8.en = e; if8.inc = i; if8.d_in = d;
    end else begin
      if4.load = l; if4.en = e; if4.inc = i; if4.d_in = d[3:0];
    end
    push(sel, ec, et, es, nm);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_cnt8"}, 32'(if8.d_out), 32'h0);
    chk({nm, "_st8"},  32'(if8.o_state), 32'h0);
    chk({nm, "_tc8"},  32'(if8.tc), 32'h0);
    chk({nm, "_cnt4"}, 32'(if4.d_out), 32'h0);
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled 2 time units after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk({e.nm, "_cnt"}, 32'(if8.d_out), 32'(e.cnt));
          chk({e.nm, "_tc"},  32'(if8.tc), 32'(e.tc));
          chk({e.nm, "_st"},  32'(if8.o_state), 32'(e.st));
        end else begin
          chk({e.nm, "_cnt"}, 32'(if4.d_out), 32'(e.cnt));
          chk({e.nm, "_tc"},  32'(if4.tc), 32'(e.tc));
          chk({e.nm, "_st"},  32'(if4.o_state), 32'(e.st));
        end
      end
    end
  end

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0;
    if8.load = 0; if8.en = 0; if8.inc = 0; if8.d_in = '0;
    if4.load = 0; if4.en = 0; if4.inc = 0; if4.d_in = '0;
    #1 reset = 1'b1;
    #1 chk_reset("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Load dominates every en/inc combination and reloads every cycle.
    row(0, 1, 0, 1, 8'hA5, 8'h00, 0, 3'b001, "ld_en0_inc1");
    row(0, 1, 0, 0, 8'hA5, 8'hA5, 0, 3'b001, "ld_en0_inc0");
    row(0, 1, 1, 0, 8'hA5, 8'hA5, 0, 3'b001, "ld_en1_inc0");
    row(0, 1, 1, 1, 8'hFE, 8'hFE, 0, 3'b001, "ld_en1_inc1");
    // Up wrap from 0xFE.
    row(0, 0, 1, 1, 8'hFE, 8'hFE, 0, 3'b010, "up_fe");
    row(0, 0, 1, 1, 8'hFE, 8'hFF, 1, 3'b010, "up_ff");
    row(0, 0, 1, 1, 8'hFE, SAT ? 8'hFF : 8'h00, 1, 3'b010, "up_wrap");
    row(0, 0, 1, 1, 8'hFE, SAT ? 8'hFF : 8'h01, SAT, 3'b010, "up_after");
    // Hold from a running up-count.
    row(0, 1, 1, 1, 8'h10, SAT ? 8'hFF : 8'h02, SAT, 3'b001, "ld_10");
    row(0, 0, 1, 1, 8'h10, 8'h10, 0, 3'b010, "cnt_10");
    row(0, 0, 1, 1, 8'h10, 8'h11, 0, 3'b010, "cnt_11");
    row(0, 0, 0, 1, 8'h10, 8'h12, 0, 3'b100, "hold_enter");
    row(0, 0, 0, 1, 8'h10, 8'h12, 0, 3'b100, "hold_1");
    row(0, 0, 0, 1, 8'h10, 8'h12, 0, 3'b100, "hold_2");
    row(0, 0, 1, 1, 8'h10, 8'h12, 0, 3'b010, "resume_st");
    row(0, 0, 1, 1, 8'h10, 8'h13, 0, 3'b010, "resume_inc");
    // Park at 0x37, then reset between edges.
    row(0, 1, 0, 0, 8'h37, 8'h14, 0, 3'b001, "ld_37");
    row(0, 0, 0, 0, 8'h37, 8'h37, 0, 3'b100, "at_37");
    row(0, 0, 0, 0, 8'h37, 8'h37, 0, 3'b100, "at_37_hold");
    drain();

    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset("mid_rst");
    @(negedge clk);
    reset = 1'b0;

    // Illegal state code recovers to IDLE and clears the count.
    row(0, 1, 0, 0, 8'h55, 8'h00, 0, 3'b001, "ld_55");
    row(0, 0, 0, 0, 8'h55, 8'h55, 0, 3'b100, "at_55");
    @(negedge clk);
    force u8.state_q = 3'b110;
    #1 release u8.state_q;
    push(0, 8'h00, 0, 3'b000, "illegal");
    row(0, 0, 0, 0, 8'h55, 8'h00, 0, 3'b100, "after_illegal");

    // 4-bit, STEP=3 down-count from 4.
    row(1, 1, 0, 0, 8'h04, 8'h00, 0, 3'b001, "d4_ld");
    row(1, 0, 1, 0, 8'h04, 8'h04, 0, 3'b011, "d4_at4");
    row(1, 0, 1, 0, 8'h04, 8'h01, 0, 3'b011, "d4_1");
    row(1, 0, 1, 0, 8'h04, SAT ? 8'h00 : 8'd14, 1, 3'b011, "d4_wrap");
    row(1, 0, 1, 0, 8'h04, SAT ? 8'h00 : 8'd11, SAT, 3'b011, "d4_next");
    row(1, 0, 0, 0, 8'h04, SAT ? 8'h00 : 8'd8, SAT, 3'b100, "d4_to_hold");
    row(1, 0, 0, 0, 8'h04, SAT ? 8'h00 : 8'd8, 0, 3'b100, "d4_hold");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
